// File: rtl/maxp_pkg.sv
// Shared types and constants for the max-pool sequencing path.
package maxp_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StFin   = 2'd3
  } maxp_state_e;

  localparam int unsigned MaxpRows  = 16;
  localparam int unsigned MaxpAddrW = 16;
  localparam int unsigned MaxpDataW = 32;
  localparam int unsigned MaxpCntW  = 10;

  localparam int unsigned MaxpWdogW = 10;
  localparam logic [MaxpWdogW-1:0] MaxpTimeoutLimit = 10'd1023;

endpackage

// File: rtl/maxp_sched_wdog.sv
// DRAIN idle watchdog for maxp_sched; instantiated only when MAXP_SCHED_TIMEOUT_EN is defined.
module maxp_sched_wdog
  import maxp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expired
);

  logic [MaxpWdogW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst || !run || kick) begin
      cnt_q <= '0;
    end else if (cnt_q != MaxpTimeoutLimit) begin
      cnt_q <= cnt_q + MaxpWdogW'(1);
    end
  end

  assign expired = run && (cnt_q == MaxpTimeoutLimit);

endmodule

// File: rtl/maxp_sched.sv
// Max-pool job sequencer: streams input-buffer reads, collects rotator results into the output
// buffer. Optional DRAIN watchdog enabled by defining MAXP_SCHED_TIMEOUT_EN.
module maxp_sched
  import maxp_pkg::*;
#(
  parameter int unsigned ADDR_W = MaxpAddrW,
  parameter int unsigned DATA_W = MaxpDataW,
  parameter int unsigned ROWS   = MaxpRows,
  parameter int unsigned CNT_W  = MaxpCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  nset,
  input  logic [CNT_W-1:0]  out_total,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  output logic [ADDR_W-1:0] a_addr,
  output logic              src_valid,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              b_wen,
  output logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;

  maxp_state_e       state_q, state_d;
  logic [ADDR_W-1:0] a_base_q, b_base_q;
  logic [CNT_W-1:0]  nset_q, out_total_q, out_cnt_q, set_q, set_n;
  logic [RowW-1:0]   row_q, row_n;
  logic [ADDR_W-1:0] a_addr_q, b_addr_q;
  logic [DATA_W-1:0] b_data_q;
  logic              src_valid_q, b_wen_q, busy_q, done_q, err_q;

  logic start_ok, res_ok, res_drop, last_row, last_issue, drain_done, timeout;

  assign start_ok   = (state_q == StIdle) && start;
  assign res_ok     = res_valid && ((state_q == StIssue) || (state_q == StDrain)) &&
                      (out_cnt_q != out_total_q);
  assign res_drop   = res_valid && !res_ok;
  assign last_row   = (row_q == RowW'(ROWS - 1));
  assign last_issue = (state_q == StIssue) && last_row && (set_q == nset_q - CNT_W'(1));
  assign drain_done = (state_q == StDrain) && (out_cnt_q == out_total_q);
  assign row_n      = last_row ? '0 : row_q + RowW'(1);
  assign set_n      = last_row ? set_q + CNT_W'(1) : set_q;

`ifdef MAXP_SCHED_TIMEOUT_EN
  logic wdog_expired;

  maxp_sched_wdog u_wdog (
    .clk     (clk),
    .rst     (rst),
    .run     (state_q == StDrain),
    .kick    (res_valid),
    .expired (wdog_expired)
  );

  // A genuine completion in the same cycle takes priority over the timeout.
  assign timeout = wdog_expired && !drain_done;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = (nset != '0) ? StIssue : StDrain;
      StIssue: if (last_issue) state_d = StDrain;
      StDrain: if (drain_done || timeout) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      a_base_q    <= '0;
      b_base_q    <= '0;
      nset_q      <= '0;
      out_total_q <= '0;
      out_cnt_q   <= '0;
      set_q       <= '0;
      row_q       <= '0;
      a_addr_q    <= '0;
      src_valid_q <= 1'b0;
      b_wen_q     <= 1'b0;
      b_addr_q    <= '0;
      b_data_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Address is valid exactly while in ISSUE; the SRAM output follows one cycle later.
      src_valid_q <= (state_q == StIssue);
      busy_q      <= (state_d == StIssue) || (state_d == StDrain);
      done_q      <= (state_d == StFin);

      if (start_ok) begin
        a_base_q    <= a_base;
        b_base_q    <= b_base;
        nset_q      <= nset;
        out_total_q <= out_total;
        out_cnt_q   <= '0;
        set_q       <= '0;
        row_q       <= '0;
        a_addr_q    <= (nset != '0) ? a_base : '0;
      end else if (state_q == StIssue) begin
        if (last_issue) begin
          set_q    <= '0;
          row_q    <= '0;
          a_addr_q <= '0;
        end else begin
          set_q    <= set_n;
          row_q    <= row_n;
          a_addr_q <= a_base_q + ADDR_W'(set_n) * ADDR_W'(ROWS) + ADDR_W'(row_n);
        end
      end

      b_wen_q <= res_ok;
      if (res_ok) begin
        b_addr_q  <= b_base_q + ADDR_W'(out_cnt_q);
        b_data_q  <= res_data;
        out_cnt_q <= out_cnt_q + CNT_W'(1);
      end

      if (res_drop || timeout) begin
        err_q <= 1'b1;
      end else if (start_ok) begin
        err_q <= 1'b0;
      end
    end
  end

  assign a_addr    = a_addr_q;
  assign src_valid = src_valid_q;
  assign b_wen     = b_wen_q;
  assign b_addr    = b_addr_q;
  assign b_data    = b_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_maxp_sched.sv
// Randomized self-checking bench for maxp_sched against a transaction-level job model.
module tb_maxp_sched;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int CW   = 10;
  localparam int ROWS = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] nset = '0;
  logic [CW-1:0] out_total = '0;
  logic [AW-1:0] a_base = '0;
  logic [AW-1:0] b_base = '0;
  logic [AW-1:0] a_addr;
  logic          src_valid;
  logic          res_valid = 1'b0;
  logic [DW-1:0] res_data = '0;
  logic          b_wen;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  maxp_sched #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .ROWS   (ROWS),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .nset      (nset),
    .out_total (out_total),
    .a_base    (a_base),
    .b_base    (b_base),
    .a_addr    (a_addr),
    .src_valid (src_valid),
    .res_valid (res_valid),
    .res_data  (res_data),
    .b_wen     (b_wen),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string pfx);
    check_eq({pfx, "_addr"}, {32'h0, a_addr, b_addr}, 64'h0);
    check_eq({pfx, "_data"}, {32'h0, b_data}, 64'h0);
    check_eq({pfx, "_ctl"}, {59'h0, src_valid, b_wen, busy, done, err}, 64'h0);
  endtask

  // One job: cycle c counts negedges after the edge that samples start. Expected behaviour:
  // a_addr = base+c for c < L, src_valid exactly in 1..L, the first tot results written in
  // order, done once at max(L, last write)+1, err at end iff any surplus result was sent.
  task automatic run_job(input int ns, input int tot, input int extra,
                         input logic [AW-1:0] ab, input logic [AW-1:0] bb);
    int L, c, sent, w, last_send, exp_done, ndone, done_c, wen_c, bad_addr, src_cnt, src_bad;
    int overlap, bad_wr;
    logic [DW-1:0] sent_data[$];
    logic [AW-1:0] got_addr[$];
    logic [DW-1:0] got_data[$];
    L = ns * ROWS;
    c = 0; sent = 0; w = 0; last_send = -1; ndone = 0; done_c = -1; wen_c = -1;
    bad_addr = 0; src_cnt = 0; src_bad = 0; overlap = 0; bad_wr = 0;
    exp_done = ((L > w) ? L : w) + 1;
    nset = CW'(ns); out_total = CW'(tot); a_base = ab; b_base = bb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("err_clr", {63'h0, err}, 64'h0);
    while (c < 2000) begin
      if (c < L && a_addr !== ab + AW'(c)) bad_addr++;
      if (src_valid) begin
        src_cnt++;
        if (c < 1 || c > L) src_bad++;
      end
      if (b_wen) begin
        got_addr.push_back(b_addr);
        got_data.push_back(b_data);
        wen_c = c;
      end
      if (done) begin
        ndone++;
        done_c = c;
      end
      if (done && busy) overlap++;
      res_valid = 1'b0;
      if (sent < tot + extra && $urandom_range(1, 0) == 1) begin
        res_data = $urandom;
        sent_data.push_back(res_data);
        res_valid = 1'b1;
        sent++;
        last_send = c;
        if (sent == tot) w = c + 1;
      end
      exp_done = ((L > w) ? L : w) + 1;
      @(negedge clk);
      res_valid = 1'b0;
      c++;
      if (sent == tot + extra && c >= exp_done + 3 && c >= last_send + 3) break;
    end
    check_eq("a_addr_seq", 64'(bad_addr), 64'h0);
    check_eq("src_cnt", 64'(src_cnt), 64'(L));
    check_eq("src_lag", 64'(src_bad), 64'h0);
    check_eq("wr_cnt", 64'(got_addr.size()), 64'(tot));
    for (int k = 0; k < got_addr.size() && k < tot; k++) begin
      if (got_addr[k] !== bb + AW'(k) || got_data[k] !== sent_data[k]) bad_wr++;
    end
    check_eq("wr_match", 64'(bad_wr), 64'h0);
    if (tot > 0) check_eq("wr_last", 64'(wen_c), 64'(w));
    check_eq("done_cnt", 64'(ndone), 64'h1);
    check_eq("done_cyc", 64'(done_c), 64'(exp_done));
    check_eq("done_busy", 64'(overlap), 64'h0);
    check_eq("err_end", {63'h0, err}, {63'h0, extra > 0});
  endtask

  initial begin
    int ns, tot, extra;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    run_job(2, 1, 0, 16'h0010, 16'h0200);
    run_job(0, 0, 0, 16'h1234, 16'h0300);

    // Result while idle: dropped and flagged.
    res_valid = 1'b1; res_data = 32'hdead_beef;
    @(negedge clk);
    res_valid = 1'b0;
    check_eq("idle_wen", {63'h0, b_wen}, 64'h0);
    check_eq("idle_err", {63'h0, err}, 64'h1);
    @(negedge clk);

    run_job(1, 3, 1, 16'h0040, 16'h0500);

    // Reset in ISSUE at set 1, row 5, with an earlier write so b_* are non-zero.
    nset = CW'(2); out_total = CW'(2); a_base = 16'h0700; b_base = 16'h0900; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < ROWS + 5; c++) begin
      res_valid = (c == 2);
      res_data = 32'h1111_2222;
      @(negedge clk);
    end
    res_valid = 1'b0;
    check_eq("pre_rst_addr", {48'h0, a_addr}, {48'h0, 16'h0700 + 16'(ROWS + 5)});
    rst = 1'b0;
    @(negedge clk);
    check_zero("rst_mid");
    rst = 1'b1;
    @(negedge clk);
    run_job(2, 2, 0, 16'h0700, 16'h0900);

    // Address wrap at the top of both buffers.
    run_job(1, 4, 0, 16'hfff8, 16'hfffe);

    for (int j = 0; j < 8; j++) begin
      ns = $urandom_range(3, 0);
      tot = $urandom_range(6, 0);
      extra = $urandom_range(1, 0);
      run_job(ns, tot, extra, AW'($urandom), AW'($urandom));
    end

`ifdef MAXP_SCHED_TIMEOUT_EN
    begin
      int wen_c, done_c;
      wen_c = -1; done_c = -1;
      nset = '0; out_total = CW'(2); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      res_valid = 1'b1; res_data = 32'h5a5a_0001;
      for (int c = 1; c < 1200 && done_c < 0; c++) begin
        @(negedge clk);
        res_valid = 1'b0;
        if (b_wen) wen_c = c;
        if (done) begin
          done_c = c;
          check_eq("tmo_err", {63'h0, err}, 64'h1);
        end
      end
      check_eq("tmo_wen", 64'(wen_c), 64'h1);
      check_eq("tmo_gap", 64'(done_c - wen_c), 64'd1024);
      repeat (2) @(negedge clk);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/maxp_sched.md
# maxp_sched

Sequencing controller for the max-pool path. On `start` it streams `nset` sets of `ROWS` words out of the input global buffer into the max-pool engine. It collects `out_total` result words from the data rotator and writes them into the output global buffer, then signals completion. It replaces the ad hoc sequencing logic in the top level and owns all buffer addressing for one pooling job.

## Interface
- `ADDR_W`, 16: word address width of both global buffers
- `DATA_W`, 32: word width
- `ROWS`, 16: rows per input set; power of two
- `CNT_W`, 10: width of `nset` and `out_total`

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-low reset
- `start` in 1: job request, sampled only in IDLE
- `nset` in CNT_W: number of input sets, latched at start
- `out_total` in CNT_W: expected result words, latched at start
- `a_base` in ADDR_W: input buffer base address, latched at start
- `b_base` in ADDR_W: output buffer base address, latched at start
- `a_addr` out ADDR_W: input buffer read address
- `src_valid` out 1: drives max-pool `DI_valid`; marks the buffer output as valid this cycle
- `res_valid` in 1: rotator output valid
- `res_data` in DATA_W: rotator output word
- `b_wen` out 1: output buffer write enable
- `b_addr` out ADDR_W: output buffer write address
- `b_data` out DATA_W: output buffer write data
- `busy` out 1: high in ISSUE and DRAIN
- `done` out 1: one-cycle completion pulse
- `err` out 1: sticky error flag, cleared on start or reset

## Operation
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - `start`=1 latches the configuration inputs and clears counters and `err`.
  - Goes to ISSUE if `nset`≠0; otherwise goes to DRAIN.
- ISSUE:
  - `a_addr = a_base + set*ROWS + row`, with no gap cycles between sets.
  - `row` wraps ROWS-1→0 and increments `set`.
  - After address (`nset`-1, ROWS-1) the FSM goes to DRAIN.
- DRAIN: waits until `out_cnt == out_total`, then goes to FIN.
- FIN: `done`=1 for one cycle, then IDLE.
- Result path, independent of state except IDLE:
  - Each `res_valid` registers `b_data=res_data`, `b_addr=b_base+out_cnt` and `b_wen`=1, then increments `out_cnt`.
- Arithmetic is modulo 2^ADDR_W; address wrap is silent.
- `out_total`=0: DRAIN exits on its first cycle.
- Boundary conditions:
  - `res_valid` in IDLE or FIN, or with `out_cnt == out_total`: word dropped (no write), `err`=1.
  - `start` while busy: ignored.
  - `start` in FIN: ignored; it must be re-asserted in IDLE.
  - Results arriving during ISSUE are accepted normally.
  - A result in the same cycle as the ISSUE→DRAIN transition is counted before the DRAIN exit check.

## Timing
- Reset: state=IDLE and all counters 0. `a_addr`=0, `src_valid`=0, `b_wen`=0, `b_addr`=0, `b_data`=0, `busy`=0, `done`=0, `err`=0.
- Reset mid-job aborts at the next edge; in-flight results are dropped without setting `err`.
- `start` at edge N: first `a_addr` valid after edge N+1.
- `src_valid` is `a_addr`-valid delayed by one cycle, matching the 1-cycle SRAM read latency. It is high for exactly `nset*ROWS` cycles.
- `res_valid` at edge M: `b_wen`/`b_addr`/`b_data` valid after M+1, high for one cycle.
- `done` is high the cycle after the last write's enable. It is never high together with `busy`.

## Configuration
- `MAXP_SCHED_TIMEOUT_EN` defined:
  - A 10-bit idle counter runs in DRAIN and resets on every `res_valid`.
  - On reaching 1023 it sets `err`=1 and forces FIN.
- Undefined: no counter; DRAIN waits indefinitely.

## Structure
- Shared package `maxp_pkg` holds:
  - the state enum (IDLE=0, ISSUE=1, DRAIN=2, FIN=3)
  - the default `ROWS`, `ADDR_W` and `DATA_W` constants
  - the timeout limit constant
- One sub-module, `maxp_sched_wdog` (the idle counter), instantiated only under the macro. Everything else stays flat.

## Test plan
- `nset`=2, `out_total`=1, `a_base`=0x10 → reads 0x10..0x2F for 32 consecutive cycles; `src_valid` 32 cycles, lagging by 1; one result at `b_base` → `done` pulse, `err`=0.
- `nset`=0, `out_total`=0 → `done` 2 cycles after start, no reads, no writes.
- `res_valid` in IDLE → no `b_wen`, `err`=1; next `start` clears `err`.
- `out_total`=3, 4 results delivered → writes at `b_base`..`b_base`+2, 4th dropped, `err`=1.
- `rst`=0 mid-ISSUE at set 1, row 5 → all outputs 0 next cycle; a new start replays from `a_base`.
- With `MAXP_SCHED_TIMEOUT_EN`, `out_total`=2, one result then silence → `done` plus `err` 1024 cycles after the last result.
